// File: rtl/ml_counter_p.sv
// ml_counter_p: multi-layer counter. It holds LAYERS = 2**SEL_W independent
// WIDTH-bit counters, and only the layer picked by s is read or updated.
// Each layer supports up/down counting, parallel load and a per-layer
// wrap/saturate mode.
//
// Ports:
//   c      clock (rising edge)
//   r      asynchronous active-low reset
//   ce     count enable for the selected layer
//   s      layer select
//   up     count direction (1 = +1, 0 = -1)
//   ld     load d into the selected layer (has priority over ce)
//   d      load value
//   msw    mode write enable for the selected layer
//   msat   mode value written on msw (0 = wrap, 1 = saturate)
//   q      combinational count of layer s
//   tc     combinational terminal count for the current direction
//   ovf    registered pulse: the previous edge wrapped or clamped a count
//   ovf_l  registered layer index belonging to the last ovf
module ml_counter_p #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SEL_W   = 6,
  parameter bit          SAT_DEF = 1'b0
) (
  input  logic             c,
  input  logic             r,
  input  logic             ce,
  input  logic [SEL_W-1:0] s,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             msw,
  input  logic             msat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic [SEL_W-1:0] ovf_l
);

  localparam int unsigned LAYERS = 2 ** SEL_W;

  logic [WIDTH-1:0] cnt  [LAYERS];
  logic             mode [LAYERS];

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             cur_sat;
  logic             at_max;
  logic             at_min;
  logic             ovf_set;

  // Read path: selected layer and its terminal-count flags, zero latency.
  always_comb begin
    cur     = cnt[s];
    cur_sat = mode[s];
    at_max  = &cur;
    at_min  = ~|cur;
    q       = cur;
    tc      = up ? at_max : at_min;
  end

  // Next value for the selected layer. Load wins over counting. At a
  // boundary the count either wraps or holds (saturate), and both raise ovf.
  always_comb begin
    nxt     = cur;
    ovf_set = 1'b0;
    if (ld) begin
      nxt = d;
    end else if (ce) begin
      if (up) begin
        if (at_max) begin
          ovf_set = 1'b1;
          nxt     = cur_sat ? cur : '0;
        end else begin
          nxt = cur + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          ovf_set = 1'b1;
          nxt     = cur_sat ? cur : '1;
        end else begin
          nxt = cur - WIDTH'(1);
        end
      end
    end
  end

  // Per-layer storage. Only the layer matching s is ever written. The mode
  // bit updates on the same edge, but this edge's count uses the old mode.
  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    logic sel;
    assign sel = (s == SEL_W'(g));

    always_ff @(posedge c or negedge r) begin
      if (!r) begin
        cnt[g]  <= '0;
        mode[g] <= SAT_DEF;
      end else if (sel) begin
        if (ld || ce) begin
          cnt[g] <= nxt;
        end
        if (msw) begin
          mode[g] <= msat;
        end
      end
    end
  end

  // Overflow pulse and the layer it belongs to. The index holds between pulses.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      ovf   <= 1'b0;
      ovf_l <= '0;
    end else begin
      ovf <= ovf_set;
      if (ovf_set) begin
        ovf_l <= s;
      end
    end
  end

endmodule

// File: tb/tb_ml_counter_p.sv
module tb_ml_counter_p;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SEL_W  = 6;
  localparam int unsigned LAYERS = 64;
  localparam int          MAXV   = 255;

  logic             c = 1'b0;
  logic             r = 1'b0;
  logic             ce = 1'b0;
  logic [SEL_W-1:0] s = '0;
  logic             up = 1'b0;
  logic             ld = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             msw = 1'b0;
  logic             msat = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic [SEL_W-1:0] ovf_l;

  ml_counter_p #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SAT_DEF(1'b0)) dut (
    .c(c), .r(r), .ce(ce), .s(s), .up(up), .ld(ld), .d(d),
    .msw(msw), .msat(msat), .q(q), .tc(tc), .ovf(ovf), .ovf_l(ovf_l)
  );

  always #5 c = ~c;

  typedef struct {
    int q;
    bit tc;
    bit ovf;
    int ovfl;
  } exp_t;

  exp_t sbq[$];

  // Reference model: plain integer counters per layer.
  int m_cnt  [LAYERS];
  bit m_mode [LAYERS];
  bit m_ovf;
  int m_ovfl;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LAYERS); i++) begin
      m_cnt[i]  = 0;
      m_mode[i] = 1'b0;
    end
    m_ovf  = 1'b0;
    m_ovfl = 0;
  endtask

  // One cycle: inputs are applied just after a rising edge. The expected
  // observation for the following falling edge is queued, then the model
  // advances for the next rising edge.
  task automatic step(input bit rr, input int ss, input bit cce, input bit uup,
                      input bit lld, input int dd, input bit mmsw, input bit mmsat);
    exp_t e;
    int   nv;
    @(posedge c);
    #1;
    r = rr; s = SEL_W'(ss); ce = cce; up = uup; ld = lld; d = WIDTH'(dd);
    msw = mmsw; msat = mmsat;
    if (!rr) model_reset();
    e.q    = m_cnt[ss];
    e.tc   = uup ? (m_cnt[ss] == MAXV) : (m_cnt[ss] == 0);
    e.ovf  = m_ovf;
    e.ovfl = m_ovfl;
    sbq.push_back(e);
    if (rr) begin
      m_ovf = 1'b0;
      if (lld) begin
        m_cnt[ss] = dd;
      end else if (cce) begin
        nv = m_cnt[ss] + (uup ? 1 : -1);
        if (nv < 0 || nv > MAXV) begin
          m_ovf  = 1'b1;
          m_ovfl = ss;
          if (!m_mode[ss]) m_cnt[ss] = (nv + MAXV + 1) % (MAXV + 1);
        end else begin
          m_cnt[ss] = nv;
        end
      end
      if (mmsw) m_mode[ss] = mmsat;
    end
  endtask

  task automatic rd(input int ss, input bit uup);
    step(1'b1, ss, 1'b0, uup, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: every falling edge, compare DUT outputs with the next queued entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge c);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("q", int'(q), e.q);
        chk("tc", int'(tc), int'(e.tc));
        chk("ovf", int'(ovf), int'(e.ovf));
        if (e.ovf) chk("ovf_l", int'(ovf_l), e.ovfl);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  int vals[4] = '{0, 1, 254, 255};

  initial begin : stim
    model_reset();
    // Reset and defaults on every layer.
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < int'(LAYERS); i++) begin
      rd(i, 1'b1);
      rd(i, 1'b0);
    end
    // Layer independence.
    repeat (3) step(1'b1, 5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 9, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rd(5, 1'b1); rd(9, 1'b1); rd(0, 1'b1);
    // Wrap up then down.
    step(1'b1, 2, 1'b0, 1'b1, 1'b1, 'hFE, 1'b0, 1'b0);
    repeat (2) step(1'b1, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rd(2, 1'b1); rd(2, 1'b1);
    step(1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rd(2, 1'b0); rd(2, 1'b0);
    // Saturate, then leave saturate mode while clamping.
    step(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 3, 1'b0, 1'b0, 1'b1, 'h00, 1'b0, 1'b0);
    repeat (2) step(1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rd(3, 1'b0);
    // Load priority over counting.
    step(1'b1, 4, 1'b0, 1'b1, 1'b1, 10, 1'b0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b1, 1'b1, 'h55, 1'b0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b1, 1'b1, 'hFF, 1'b0, 1'b0);
    rd(4, 1'b1); rd(4, 1'b1);
    // Async reset mid-count; layer 6 in saturate mode must return to wrap.
    step(1'b1, 6, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 1, 1'b0, 1'b1, 1'b1, 'h20, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b1, 1'b1, 'h20, 1'b0, 1'b0);
    step(1'b1, 7, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rd(1, 1'b1); rd(7, 1'b0);
    step(1'b1, 6, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rd(6, 1'b1);
    // Randomised traffic, biased toward the boundary values.
    for (int n = 0; n < 3000; n++) begin
      int  ss;
      int  dd;
      bit  rr;
      ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAYERS - 1))
                                       : int'($urandom_range(0, 5));
      dd = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 3)]
                                       : int'($urandom_range(0, MAXV));
      rr = ($urandom_range(0, 499) != 0);
      step(rr, ss, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), dd, ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)));
    end
    // Final read sweep of every layer.
    for (int i = 0; i < int'(LAYERS); i++) rd(i, 1'($urandom_range(0, 1)));
    @(posedge c);
    @(negedge c);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ml_counter_p.md
Name: ml_counter_p

Overview:
- Parametrised multi-layer counter: 2**SEL_W independent WIDTH-bit count contexts ("layers"); input s selects the one active layer.
- Only the selected layer is read or modified in a given cycle; every other layer holds its value.
- Generalises the fixed 8-bit / 64-layer up-counter with: up/down counting, parallel load, wrap or saturate mode, terminal-count flag and a registered overflow pulse.
- Used wherever several time-multiplexed channels each need their own counter.

Parameters:
- WIDTH, 8, bits per layer counter (>=2).
- SEL_W, 6, layer-select width; LAYERS = 2**SEL_W.
- SAT_DEF, 0, reset value of the per-layer saturate-mode bit (0 = wrap, 1 = saturate).

Ports:
- c  input  1  clock; all state changes on rising edge.
- r  input  1  asynchronous active-low reset.
- ce  input  1  count enable for the selected layer.
- s  input  SEL_W  layer select; may change every cycle.
- up  input  1  direction: 1 = +1, 0 = -1.
- ld  input  1  synchronous load of d into the selected layer.
- d  input  WIDTH  load value.
- msw  input  1  mode write: when high, the selected layer's mode bit takes the value of msat.
- msat  input  1  mode value written on msw.
- q  output  WIDTH  combinational value of layer s (contents before the next edge).
- tc  output  1  combinational terminal count: q==all-ones when up=1, q==0 when up=0.
- ovf  output  1  registered one-cycle pulse: the previous edge wrapped or clamped a count.
- ovf_l  output  SEL_W  registered layer index belonging to ovf.

Behaviour:
Storage and reset:
- Storage is cnt[LAYERS][WIDTH] plus mode[LAYERS].
- r low (asynchronous): all cnt = 0, all mode = SAT_DEF, ovf = 0, ovf_l = 0.
- While r is low, q = 0 and tc = ~up.
- Release of r is synchronised by the user. No transient state exists, so a reset mid-operation simply clears everything.

Read path:
- q = cnt[s] and tc reflect s, up and cnt with zero latency.
- No pipeline: a write at edge k is visible on q immediately after edge k when s is unchanged.

Update at each rising edge of c, for layer L = s only (priority order):
1. ld=1: cnt[L] <= d; no ovf, regardless of ce.
2. Else ce=1 and up=1:
   - cnt[L] == 2**WIDTH-1, wrap mode: cnt[L] <= 0, ovf <= 1.
   - Same value, saturate mode: cnt[L] holds, ovf <= 1.
   - Otherwise: cnt[L] <= cnt[L] + 1.
3. Else ce=1 and up=0:
   - cnt[L] == 0, wrap mode: cnt[L] <= all-ones, ovf <= 1.
   - Same value, saturate mode: cnt[L] holds, ovf <= 1.
   - Otherwise: cnt[L] <= cnt[L] - 1.
4. Else: cnt[L] holds.

ovf and ovf_l:
- ovf <= 0 on every edge where case 2/3 did not set it.
- ovf_l <= L on edges where ovf is set, otherwise holds.

Mode write:
- msw=1: mode[L] <= msat.
- The new mode applies from the next edge. The count on the same edge uses the old mode.
- msw is independent of ld/ce; both may occur on the same edge.

General rules:
- Arithmetic is modulo 2**WIDTH, unsigned. No carry chain between layers.
- Layers not equal to s are never written, even when ce/ld/msw are high.
- s changing between edges has no side effects. A layer's value persists indefinitely.

Test Plan:
- Reset and default: r low then high with SAT_DEF=0. For s=0..LAYERS-1 with up=1 -> q=0, tc=0 on every layer; with up=0 -> tc=1; ovf=0.
- Layer independence (WIDTH=8, SEL_W=6): s=5, ce=1, up=1 for 3 edges; s=9 for 7 edges; s=5 again -> q=3; s=9 -> q=7; s=0 -> q=0; ovf never set.
- Wrap up/down: s=2, ld d=8'hFE, then ce=1 up=1 for 2 edges -> q=8'hFF with tc=1, then q=8'h00 with ovf=1 and ovf_l=2 for exactly one cycle. Then up=0, one edge -> q=8'hFF, ovf=1.
- Saturate: s=3, msw=1 msat=1, then ld d=8'h00, ce=1 up=0 for 2 edges -> q stays 8'h00, ovf=1 on both edges. msw=1 msat=0, one more down edge (still clamps, since the old mode is used on that edge), next edge -> q=8'hFF.
- Load priority: s=4, cnt=10, ld=1 ce=1 up=1 d=8'h55 -> q=8'h55, ovf=0. With ld=1 d=8'hFF ce=1 -> q=8'hFF, not 8'h00.
- Async reset mid-count: layers 1 and 7 loaded with 8'h20, ce=1; r pulsed low between clock edges -> q=0 immediately, all layers 0, ovf=0, mode returns to SAT_DEF.
